obi_bus_arbiter: RTL and testbench

//  Arbitrates the CV32E40X instruction-fetch and data OBI ports onto the single SoC OBI bus.

---
 rtl/obi_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_obi_bus_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_bus_arbiter.sv
// obi_bus_arbiter
//   Merges the CV32E40X instruction-fetch and data OBI ports onto the single
//   SoC OBI bus. Only one transaction can be outstanding at a time. The port
//   that wins arbitration owns the bus from its address phase until its
//   response. A response watchdog completes transactions whose slave never
//   answers, so the core cannot stall forever on an unmapped or dead slave.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   instr_*                 fetch-side OBI port (read only)
//   data_*                  data-side OBI port
//   soc_*                   arbitrated OBI port towards the SoC bus
//   timeout_o               sticky flag: a watchdog completion has occurred
//   busy_o                  high while a transaction is in address or response phase

module obi_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter bit          RR_ENABLE      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [3:0]            data_be_i,
  input  logic                  data_we_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  soc_req_o,
  input  logic                  soc_gnt_i,
  input  logic                  soc_rvalid_i,
  output logic [ADDR_WIDTH-1:0] soc_addr_o,
  output logic [3:0]            soc_be_o,
  output logic                  soc_we_o,
  output logic [31:0]           soc_wdata_o,
  input  logic [31:0]           soc_rdata_i,
  output logic                  timeout_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  owner_e      winner;
  owner_e      sel;
  logic        gnt_fire;
  logic        resp_real;
  logic        resp_tout;
  logic        resp_fire;
  logic [31:0] resp_data;

  // Winner is forced to NONE while reset is asserted so that no bus request
  // or grant leaks out combinationally from a port that is still requesting.
  always_comb begin
    winner = OWN_NONE;
    if (rst_ni) begin
      if (instr_req_i && data_req_i) begin
        if (!RR_ENABLE) begin
          winner = OWN_DATA;
        end else begin
          winner = (last_q == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        end
      end else if (data_req_i) begin
        winner = OWN_DATA;
      end else if (instr_req_i) begin
        winner = OWN_INSTR;
      end
    end
  end

  // In IDLE the winner drives the bus directly (zero added latency);
  // afterwards the locked owner does.
  assign sel = (state_q == ST_IDLE) ? winner : owner_q;

  always_comb begin
    soc_addr_o  = '0;
    soc_be_o    = '0;
    soc_we_o    = 1'b0;
    soc_wdata_o = '0;
    case (sel)
      OWN_INSTR: begin
        soc_addr_o = instr_addr_i;
        soc_be_o   = 4'hF;
      end
      OWN_DATA: begin
        soc_addr_o  = data_addr_i;
        soc_be_o    = data_be_i;
        soc_we_o    = data_we_i;
        soc_wdata_o = data_wdata_i;
      end
      default: ;
    endcase
  end

  assign soc_req_o   = ((state_q == ST_IDLE) && (winner != OWN_NONE)) || (state_q == ST_ADDR);
  assign gnt_fire    = soc_req_o && soc_gnt_i;
  assign instr_gnt_o = gnt_fire && (sel == OWN_INSTR);
  assign data_gnt_o  = gnt_fire && (sel == OWN_DATA);

  // A real response always beats a watchdog expiry in the same cycle.
  // Responses arriving outside RESP are simply never forwarded.
  assign resp_real = (state_q == ST_RESP) && soc_rvalid_i;
  assign resp_tout = WDOG_EN && (state_q == ST_RESP) && !soc_rvalid_i && (cnt_q == CNT_LAST);
  assign resp_fire = resp_real || resp_tout;
  assign resp_data = resp_real ? soc_rdata_i : TIMEOUT_RDATA;

  assign instr_rvalid_o = resp_fire && (owner_q == OWN_INSTR);
  assign data_rvalid_o  = resp_fire && (owner_q == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? resp_data : 32'h0;
  assign data_rdata_o   = data_rvalid_o ? resp_data : 32'h0;

  assign busy_o    = (state_q != ST_IDLE);
  assign timeout_o = timeout_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          owner_d = winner;
          if (soc_gnt_i) begin
            state_d = ST_RESP;
            last_d  = winner;
            cnt_d   = '0;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (soc_gnt_i) begin
          state_d = ST_RESP;
          last_d  = owner_q;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        if (resp_fire) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          if (resp_tout) begin
            timeout_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      last_q    <= OWN_INSTR;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_obi_bus_arbiter.sv
// Directed bench for obi_bus_arbiter. Two instances share every input:
// dut0 uses fixed data priority, dut1 uses round-robin; both use an
// 8-cycle response watchdog. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.

module tb_obi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        data_req = 1'b0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_be = '0;
  logic        data_we = 1'b0;
  logic [31:0] data_wdata = '0;
  logic        soc_gnt = 1'b0;
  logic        soc_rvalid = 1'b0;
  logic [31:0] soc_rdata = '0;

  logic        instr_gnt_0, instr_rvalid_0, data_gnt_0, data_rvalid_0;
  logic [31:0] instr_rdata_0, data_rdata_0, soc_addr_0, soc_wdata_0;
  logic        soc_req_0, soc_we_0, timeout_0, busy_0;
  logic [3:0]  soc_be_0;

  logic        instr_gnt_1, instr_rvalid_1, data_gnt_1, data_rvalid_1;
  logic [31:0] instr_rdata_1, data_rdata_1, soc_addr_1, soc_wdata_1;
  logic        soc_req_1, soc_we_1, timeout_1, busy_1;
  logic [3:0]  soc_be_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_bus_arbiter #(
    .ADDR_WIDTH(32), .RR_ENABLE(1'b0), .TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEADBEEF)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt_0), .instr_rvalid_o(instr_rvalid_0),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata_0),
    .data_req_i(data_req), .data_gnt_o(data_gnt_0), .data_rvalid_o(data_rvalid_0),
    .data_addr_i(data_addr), .data_be_i(data_be), .data_we_i(data_we),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata_0),
    .soc_req_o(soc_req_0), .soc_gnt_i(soc_gnt), .soc_rvalid_i(soc_rvalid),
    .soc_addr_o(soc_addr_0), .soc_be_o(soc_be_0), .soc_we_o(soc_we_0),
    .soc_wdata_o(soc_wdata_0), .soc_rdata_i(soc_rdata),
    .timeout_o(timeout_0), .busy_o(busy_0)
  );

  obi_bus_arbiter #(
    .ADDR_WIDTH(32), .RR_ENABLE(1'b1), .TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEADBEEF)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt_1), .instr_rvalid_o(instr_rvalid_1),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata_1),
    .data_req_i(data_req), .data_gnt_o(data_gnt_1), .data_rvalid_o(data_rvalid_1),
    .data_addr_i(data_addr), .data_be_i(data_be), .data_we_i(data_we),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata_1),
    .soc_req_o(soc_req_1), .soc_gnt_i(soc_gnt), .soc_rvalid_i(soc_rvalid),
    .soc_addr_o(soc_addr_1), .soc_be_o(soc_be_1), .soc_we_o(soc_we_1),
    .soc_wdata_o(soc_wdata_1), .soc_rdata_i(soc_rdata),
    .timeout_o(timeout_1), .busy_o(busy_1)
  );

  task automatic clear_inputs();
    instr_req  = 1'b0;
    instr_addr = '0;
    data_req   = 1'b0;
    data_addr  = '0;
    data_be    = '0;
    data_we    = 1'b0;
    data_wdata = '0;
    soc_gnt    = 1'b0;
    soc_rvalid = 1'b0;
    soc_rdata  = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Slave inputs are active during reset: nothing may reach the core.
  task automatic test_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    clear_inputs();
    soc_gnt = 1'b1;
    soc_rvalid = 1'b1;
    soc_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({soc_req_0, instr_gnt_0, data_gnt_0, instr_rvalid_0, data_rvalid_0, busy_0, timeout_0, soc_we_0} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
               {soc_req_0, instr_gnt_0, data_gnt_0, instr_rvalid_0, data_rvalid_0, busy_0, timeout_0, soc_we_0});
    end
    checks++;
    if ({soc_addr_0, soc_wdata_0, instr_rdata_0, data_rdata_0, soc_be_0} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: addr %h wdata %h irdata %h drdata %h be %h expected all 0",
               soc_addr_0, soc_wdata_0, instr_rdata_0, data_rdata_0, soc_be_0);
    end
    clear_inputs();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_fetch_only();
    apply_reset();
    @(negedge clk);
    instr_req = 1'b1; instr_addr = 32'h0000_0100; soc_gnt = 1'b1;
    #1;
    checks++;
    if ({instr_gnt_0, data_gnt_0, soc_req_0} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL fetch_gnt: got ignt/dgnt/req %b expected 101", {instr_gnt_0, data_gnt_0, soc_req_0});
    end
    checks++;
    if (soc_addr_0 !== 32'h100 || soc_be_0 !== 4'hF || soc_we_0 !== 1'b0 || soc_wdata_0 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL fetch_bus: got addr %h be %h we %b wdata %h expected 00000100 f 0 00000000",
               soc_addr_0, soc_be_0, soc_we_0, soc_wdata_0);
    end
    @(negedge clk);
    instr_req = 1'b0; soc_gnt = 1'b0; soc_rvalid = 1'b1; soc_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (instr_rvalid_0 !== 1'b1 || instr_rdata_0 !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL fetch_resp: got rvalid %b rdata %h expected 1 12345678", instr_rvalid_0, instr_rdata_0);
    end
    checks++;
    if ({data_rvalid_0, data_gnt_0, soc_req_0, busy_0} !== 4'b0001 || data_rdata_0 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL fetch_quiet: got drv/dgnt/req/busy %b drdata %h expected 0001 00000000",
               {data_rvalid_0, data_gnt_0, soc_req_0, busy_0}, data_rdata_0);
    end
    @(negedge clk);
    soc_rvalid = 1'b0; soc_rdata = '0;
    #1;
    checks++;
    if (busy_0 !== 1'b0 || instr_rvalid_0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_idle: got busy %b rvalid %b expected 0 0", busy_0, instr_rvalid_0);
    end
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    instr_addr = 32'h0000_0800;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_req = 1'b1; data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
      data_addr = 32'h0000_2000 + 32'(i * 4); data_wdata = 32'(i);
      soc_gnt = 1'b1; soc_rvalid = 1'b0;
      #1;
      checks++;
      if ({data_gnt_0, instr_gnt_0} !== 2'b10 || soc_addr_0 !== data_addr) begin
        errors++;
        $display("[TB] FAIL prio_gnt[%0d]: got dgnt/ignt %b addr %h expected 10 %h",
                 i, {data_gnt_0, instr_gnt_0}, soc_addr_0, data_addr);
      end
      @(negedge clk);
      soc_gnt = 1'b0; soc_rvalid = 1'b1; soc_rdata = 32'hA0 + 32'(i);
      #1;
      checks++;
      if ({data_rvalid_0, instr_rvalid_0} !== 2'b10 || data_rdata_0 !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("[TB] FAIL prio_resp[%0d]: got drv/irv %b rdata %h expected 10 %h",
                 i, {data_rvalid_0, instr_rvalid_0}, data_rdata_0, 32'hA0 + 32'(i));
      end
    end
    @(negedge clk);
    data_req = 1'b0; soc_gnt = 1'b1; soc_rvalid = 1'b0;
    #1;
    checks++;
    if ({data_gnt_0, instr_gnt_0} !== 2'b01 || soc_addr_0 !== 32'h800 || soc_we_0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_fetch: got dgnt/ignt %b addr %h we %b expected 01 00000800 0",
               {data_gnt_0, instr_gnt_0}, soc_addr_0, soc_we_0);
    end
    @(negedge clk);
    instr_req = 1'b0; soc_gnt = 1'b0; soc_rvalid = 1'b1; soc_rdata = 32'h0000_0013;
    #1;
    checks++;
    if (instr_rvalid_0 !== 1'b1 || instr_rdata_0 !== 32'h13 || data_rvalid_0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_fetch_resp: got irv %b rdata %h drv %b expected 1 00000013 0",
               instr_rvalid_0, instr_rdata_0, data_rvalid_0);
    end
    @(negedge clk);
    soc_rvalid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_pat;
    apply_reset();
    instr_addr = 32'h0000_0900; data_addr = 32'h0000_4000; data_be = 4'hF;
    for (int i = 0; i < 6; i++) begin
      exp_pat = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      instr_req = 1'b1; data_req = 1'b1; soc_gnt = 1'b1; soc_rvalid = 1'b0;
      #1;
      checks++;
      if ({data_gnt_1, instr_gnt_1} !== exp_pat) begin
        errors++;
        $display("[TB] FAIL rr_gnt[%0d]: got dgnt/ignt %b expected %b", i, {data_gnt_1, instr_gnt_1}, exp_pat);
      end
      @(negedge clk);
      soc_gnt = 1'b0; soc_rvalid = 1'b1; soc_rdata = 32'(i);
      #1;
      checks++;
      if ({data_rvalid_1, instr_rvalid_1} !== exp_pat) begin
        errors++;
        $display("[TB] FAIL rr_resp[%0d]: got drv/irv %b expected %b", i, {data_rvalid_1, instr_rvalid_1}, exp_pat);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_addr_hold();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      instr_req = 1'b1; instr_addr = 32'h0000_0A00;
      data_req = 1'b1; data_addr = 32'h3000_0010; data_we = 1'b1; data_be = 4'h3;
      data_wdata = 32'hCAFE_F00D;
      soc_gnt = (c == 4);
      #1;
      checks++;
      if (soc_req_0 !== 1'b1 || soc_addr_0 !== 32'h3000_0010 || soc_we_0 !== 1'b1 ||
          soc_be_0 !== 4'h3 || soc_wdata_0 !== 32'hCAFE_F00D) begin
        errors++;
        $display("[TB] FAIL hold_bus[%0d]: got req %b addr %h we %b be %h wdata %h expected 1 30000010 1 3 cafef00d",
                 c, soc_req_0, soc_addr_0, soc_we_0, soc_be_0, soc_wdata_0);
      end
      checks++;
      if ({data_gnt_0, instr_gnt_0, busy_0} !== {(c == 4), 1'b0, (c != 0)}) begin
        errors++;
        $display("[TB] FAIL hold_gnt[%0d]: got dgnt/ignt/busy %b expected %b",
                 c, {data_gnt_0, instr_gnt_0, busy_0}, {(c == 4), 1'b0, (c != 0)});
      end
    end
    @(negedge clk);
    instr_req = 1'b0; data_req = 1'b0; soc_gnt = 1'b0; soc_rvalid = 1'b1; soc_rdata = 32'h0;
    #1;
    checks++;
    if ({data_rvalid_0, instr_rvalid_0, soc_req_0} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL hold_resp: got drv/irv/req %b expected 100", {data_rvalid_0, instr_rvalid_0, soc_req_0});
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    @(negedge clk);
    instr_req = 1'b1; instr_addr = 32'h0000_0400; soc_gnt = 1'b1;
    #1;
    checks++;
    if (instr_gnt_0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wd_gnt: got %b expected 1", instr_gnt_0);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      instr_req = 1'b0; soc_gnt = 1'b0;
      #1;
      if (k < 8) begin
        checks++;
        if (instr_rvalid_0 !== 1'b0 || busy_0 !== 1'b1) begin
          errors++;
          $display("[TB] FAIL wd_wait[%0d]: got rvalid %b busy %b expected 0 1", k, instr_rvalid_0, busy_0);
        end
      end else begin
        checks++;
        if (instr_rvalid_0 !== 1'b1 || instr_rdata_0 !== 32'hDEAD_BEEF || timeout_0 !== 1'b0 || data_rvalid_0 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL wd_fire: got rvalid %b rdata %h timeout %b drv %b expected 1 deadbeef 0 0",
                   instr_rvalid_0, instr_rdata_0, timeout_0, data_rvalid_0);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (timeout_0 !== 1'b1 || busy_0 !== 1'b0 || instr_rvalid_0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wd_sticky: got timeout %b busy %b rvalid %b expected 1 0 0", timeout_0, busy_0, instr_rvalid_0);
    end
    @(negedge clk);
    soc_rvalid = 1'b1; soc_rdata = 32'h5555_5555;
    #1;
    checks++;
    if ({instr_rvalid_0, data_rvalid_0} !== 2'b00 || instr_rdata_0 !== 32'h0 || timeout_0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wd_late: got irv/drv %b irdata %h timeout %b expected 00 00000000 1",
               {instr_rvalid_0, data_rvalid_0}, instr_rdata_0, timeout_0);
    end
    @(negedge clk);
    soc_rvalid = 1'b0; soc_rdata = '0;
  endtask

  // Enters from the previous test with timeout_o already set.
  task automatic test_reset_mid();
    @(negedge clk);
    instr_req = 1'b1; instr_addr = 32'h0000_0500; soc_gnt = 1'b1;
    @(negedge clk);
    instr_req = 1'b0; soc_gnt = 1'b0;
    #1;
    checks++;
    if (busy_0 !== 1'b1 || timeout_0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pre: got busy %b timeout %b expected 1 1", busy_0, timeout_0);
    end
    #1;
    rst_ni = 1'b0; soc_rvalid = 1'b1; soc_rdata = 32'h7777_7777;
    #1;
    checks++;
    if ({busy_0, timeout_0, instr_rvalid_0, data_rvalid_0, soc_req_0} !== 5'b0 || instr_rdata_0 !== 32'h0 || soc_addr_0 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got busy/to/irv/drv/req %b irdata %h addr %h expected 00000 00000000 00000000",
               {busy_0, timeout_0, instr_rvalid_0, data_rvalid_0, soc_req_0}, instr_rdata_0, soc_addr_0);
    end
    @(negedge clk);
    rst_ni = 1'b1; soc_rvalid = 1'b0; soc_rdata = '0;
    @(negedge clk);
    instr_req = 1'b1; instr_addr = 32'h0000_0600; soc_gnt = 1'b1;
    #1;
    checks++;
    if (instr_gnt_0 !== 1'b1 || soc_addr_0 !== 32'h600) begin
      errors++;
      $display("[TB] FAIL mid_refetch: got gnt %b addr %h expected 1 00000600", instr_gnt_0, soc_addr_0);
    end
    @(negedge clk);
    instr_req = 1'b0; soc_gnt = 1'b0; soc_rvalid = 1'b1; soc_rdata = 32'h0BAD_CAFE;
    #1;
    checks++;
    if (instr_rvalid_0 !== 1'b1 || instr_rdata_0 !== 32'h0BAD_CAFE) begin
      errors++;
      $display("[TB] FAIL mid_refetch_resp: got rvalid %b rdata %h expected 1 0badcafe", instr_rvalid_0, instr_rdata_0);
    end
    @(negedge clk);
    soc_rvalid = 1'b0;
  endtask

  // Real response arriving in the very cycle the watchdog would expire.
  task automatic test_timeout_race();
    apply_reset();
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h0000_7000; data_be = 4'hF; soc_gnt = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      data_req = 1'b0; soc_gnt = 1'b0; soc_rvalid = (k == 8); soc_rdata = 32'h600D_F00D;
    end
    #1;
    checks++;
    if (data_rvalid_0 !== 1'b1 || data_rdata_0 !== 32'h600D_F00D) begin
      errors++;
      $display("[TB] FAIL race_resp: got rvalid %b rdata %h expected 1 600df00d", data_rvalid_0, data_rdata_0);
    end
    @(negedge clk);
    soc_rvalid = 1'b0;
    #1;
    checks++;
    if (timeout_0 !== 1'b0 || busy_0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL race_flag: got timeout %b busy %b expected 0 0", timeout_0, busy_0);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_fetch_only();
    test_fixed_priority();
    test_round_robin();
    test_addr_hold();
    test_timeout();
    test_reset_mid();
    test_timeout_race();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion expected completion");
    $fatal(1);
  end

endmodule
